videomem_arbiter: RTL and testbench
===================================

VIDEOMEM_ARBITER -- requirements
Module: videomem_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 4, data beats per granted access (power of two, 2..16).
REQ-002 Parameter ADDR_W, default 25, word-address width of all address ports.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: port mem_clock (in, 1, sole clock) and port reset_n (in, 1, async active-low reset).
REQ-004 mem_ready  in  1  controller initialised; low forces the idle condition (REQ-012).
REQ-005 rd_request  in  1  display reader burst request; rd_addr  in  ADDR_W  reader start address.
REQ-006 rd_req_ack  out  1  one-cycle accept to reader; rd_data  out  32  read beat; rd_data_valid  out  1  beat strobe.
REQ-007 wr_request  in  1  writer burst request; wr_addr  in  ADDR_W; wr_data  in  32  current write beat.
REQ-008 wr_req_ack  out  1  one-cycle accept to writer; give_next_data  out  1  writer advances to next beat.
REQ-009 mc_request  out  1; mc_addr  out  ADDR_W; mc_write  out  1 (1=write); mc_wdata  out  32 -- controller request side.
REQ-010 mc_req_ack  in  1; mc_give_next_data  in  1; mc_rdata  in  32; mc_rdata_valid  in  1 -- controller response side.
REQ-011 owner  out  2  current grant (00 none, 01 reader, 10 writer); busy  out  1  burst in flight.

Function
REQ-012 States SHALL be IDLE, REQ, BURST; mem_ready low in any state SHALL return to IDLE next cycle, drop mc_request, clear owner and beat counter.
REQ-013 IDLE: if mem_ready and any requester high, select winner, register mc_addr/mc_write/owner, go REQ next cycle; otherwise stay.
REQ-014 Selection: reader wins if rd_request high and (writer idle or priority favours reader per REQ-023); else writer.
REQ-015 REQ: mc_request held high until the cycle mc_req_ack=1; in that cycle the arbiter SHALL pulse rd_req_ack or wr_req_ack (combinational pass-through, same cycle) and go BURST.
REQ-016 mc_request SHALL drop the cycle after mc_req_ack; mc_addr and mc_write SHALL be stable while mc_request is high.
REQ-017 BURST write: give_next_data = mc_give_next_data when owner=10, else 0; mc_wdata = wr_data combinationally.
REQ-018 BURST read: rd_data = mc_rdata, rd_data_valid = mc_rdata_valid when owner=01, else 0.
REQ-019 A beat counter (log2 BURST_LEN bits) SHALL count beats; on the BURST_LEN-th beat the arbiter SHALL return to IDLE next cycle (wrap to 0).
REQ-020 A request dropped by its requester while in REQ SHALL NOT cancel mc_request (no withdrawal once issued).
REQ-021 busy = 1 in REQ and BURST; owner valid from REQ entry until IDLE return.
REQ-022 Beat strobes arriving in IDLE or REQ SHALL be ignored and not forwarded.

Reset
REQ-023 On reset_n low: state IDLE; mc_request, rd_req_ack, wr_req_ack, give_next_data, rd_data_valid, busy = 0; owner = 00; mc_addr = 0; mc_write = 0; beat counter 0; last-winner flag = writer (so reader wins first contest).
REQ-024 Reset release SHALL take effect on the first mem_clock edge after reset_n rises; no arbitration before mem_ready high.

Configuration
REQ-025 Macro VIDEOMEM_ARB_RR_EN: defined -> round-robin on contention (winner is the opposite of last winner); undefined -> fixed priority, reader always wins contention.

Verification
REQ-026 Reset then mem_ready=1, rd_request=1 rd_addr=0x100 -> mc_request=1, mc_write=0, mc_addr=0x100, owner=01; ack -> rd_req_ack pulse, 4 rdata_valid forwarded, IDLE.
REQ-027 wr_request=1 wr_addr=0x2000, wr_data=0xFFFFFFFF -> mc_write=1; 4 mc_give_next_data -> 4 give_next_data, mc_wdata tracks wr_data, owner=10 then 00.
REQ-028 Both request every cycle, RR_EN defined -> grants alternate R,W,R,W over 4 bursts; undefined -> 4 reader grants, writer none.
REQ-029 mem_ready dropped mid-BURST after 2 beats -> next cycle IDLE, mc_request=0, owner=00, counter 0; later bursts count 4 beats from 0.
REQ-030 mc_rdata_valid pulsed while IDLE -> rd_data_valid stays 0; reset_n low mid-REQ -> all outputs at REQ-023 values immediately.

Source files
------------

// File: rtl/videomem_arbiter_if.sv
// videomem_arbiter_if -- client, controller and status signals of the video
// memory arbiter, bundled so the arbiter and its environment share one view.
//   master : the arbiter side (drives acks, beat strobes and the controller request)
//   slave  : the environment side (reader, writer and memory controller)
interface videomem_arbiter_if #(
    parameter int ADDR_W = 25
);
    // display reader
    logic              rd_request;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_req_ack;
    logic [31:0]       rd_data;
    logic              rd_data_valid;

    // writer
    logic              wr_request;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_req_ack;
    logic              give_next_data;

    // memory controller request side
    logic              mc_request;
    logic [ADDR_W-1:0] mc_addr;
    logic              mc_write;
    logic [31:0]       mc_wdata;

    // memory controller response side
    logic              mc_req_ack;
    logic              mc_give_next_data;
    logic [31:0]       mc_rdata;
    logic              mc_rdata_valid;

    // status
    logic [1:0]        owner;
    logic              busy;

    modport master (
        input  rd_request, rd_addr,
        input  wr_request, wr_addr, wr_data,
        input  mc_req_ack, mc_give_next_data, mc_rdata, mc_rdata_valid,
        output rd_req_ack, rd_data, rd_data_valid,
        output wr_req_ack, give_next_data,
        output mc_request, mc_addr, mc_write, mc_wdata,
        output owner, busy
    );

    modport slave (
        output rd_request, rd_addr,
        output wr_request, wr_addr, wr_data,
        output mc_req_ack, mc_give_next_data, mc_rdata, mc_rdata_valid,
        input  rd_req_ack, rd_data, rd_data_valid,
        input  wr_req_ack, give_next_data,
        input  mc_request, mc_addr, mc_write, mc_wdata,
        input  owner, busy
    );
endinterface

// File: rtl/videomem_arbiter.sv
// videomem_arbiter -- shares one memory-controller port between a display
// reader and a writer, one fixed-length burst at a time.
//
// Optional feature: define VIDEOMEM_ARB_RR_EN to make contention round-robin
// (winner is the opposite of the previous winner). Without it the reader
// always wins contention.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no grant; arbitrates when mem_ready is high
// ST_REQ   | mc_request held high for the winner until mc_req_ack
// ST_BURST | beats forwarded to/from the owner until BURST_LEN beats seen
//
// BURST_LEN must be a power of two in 2..16 so the beat counter wraps
// naturally at the terminal count.
module videomem_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int ADDR_W    = 25
) (
    input  logic                mem_clock,
    input  logic                reset_n,
    input  logic                mem_ready,
    videomem_arbiter_if.master  bus
);

    localparam int CNT_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_RD   = 2'b01;
    localparam logic [1:0] OWN_WR   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mc_request_q, mc_request_d;
    logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
    logic              mc_write_q, mc_write_d;
    logic [1:0]        owner_q, owner_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              last_wr_q, last_wr_d;

    logic              any_req;
    logic              rd_favoured;
    logic              rd_wins;
    logic              in_req;
    logic              in_burst;
    logic              owner_rd;
    logic              owner_wr;
    logic              beat;

    assign in_req   = (state_q == ST_REQ);
    assign in_burst = (state_q == ST_BURST);
    assign owner_rd = (owner_q == OWN_RD);
    assign owner_wr = (owner_q == OWN_WR);

    // Contention policy: who wins when both clients request in the same cycle.
    always_comb begin
        rd_favoured = 1'b1;
`ifdef VIDEOMEM_ARB_RR_EN
        rd_favoured = last_wr_q;
`else
        rd_favoured = 1'b1;
`endif
        any_req = bus.rd_request | bus.wr_request;
        rd_wins = bus.rd_request & (~bus.wr_request | rd_favoured);
    end

    // A beat is the owner's strobe during BURST; strobes for the other client
    // or outside BURST are neither counted nor forwarded.
    always_comb begin
        beat = 1'b0;
        if (in_burst && mem_ready) begin
            if (owner_rd) begin
                beat = bus.mc_rdata_valid;
            end else if (owner_wr) begin
                beat = bus.mc_give_next_data;
            end
        end
    end

    // Next-state and registered-output computation for the arbitration FSM.
    always_comb begin
        state_d      = state_q;
        mc_request_d = mc_request_q;
        mc_addr_d    = mc_addr_q;
        mc_write_d   = mc_write_q;
        owner_d      = owner_q;
        busy_d       = busy_q;
        beat_cnt_d   = beat_cnt_q;
        last_wr_d    = last_wr_q;

        if (!mem_ready) begin
            // controller not usable: abandon whatever was in flight
            state_d      = ST_IDLE;
            mc_request_d = 1'b0;
            owner_d      = OWN_NONE;
            busy_d       = 1'b0;
            beat_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_d      = ST_REQ;
                        mc_request_d = 1'b1;
                        busy_d       = 1'b1;
                        beat_cnt_d   = '0;
                        if (rd_wins) begin
                            mc_addr_d  = bus.rd_addr;
                            mc_write_d = 1'b0;
                            owner_d    = OWN_RD;
                            last_wr_d  = 1'b0;
                        end else begin
                            mc_addr_d  = bus.wr_addr;
                            mc_write_d = 1'b1;
                            owner_d    = OWN_WR;
                            last_wr_d  = 1'b1;
                        end
                    end
                end

                ST_REQ: begin
                    // the client may have dropped its request; once issued,
                    // the controller request stays up until acknowledged
                    if (bus.mc_req_ack) begin
                        state_d      = ST_BURST;
                        mc_request_d = 1'b0;
                    end
                end

                ST_BURST: begin
                    if (beat) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_d    = ST_IDLE;
                            owner_d    = OWN_NONE;
                            busy_d     = 1'b0;
                            beat_cnt_d = '0;
                        end else begin
                            beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state_d      = ST_IDLE;
                    mc_request_d = 1'b0;
                    owner_d      = OWN_NONE;
                    busy_d       = 1'b0;
                    beat_cnt_d   = '0;
                end
            endcase
        end
    end

    // State and registered outputs; the first contest after reset goes to the reader.
    always_ff @(posedge mem_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            mc_request_q <= 1'b0;
            mc_addr_q    <= '0;
            mc_write_q   <= 1'b0;
            owner_q      <= OWN_NONE;
            busy_q       <= 1'b0;
            beat_cnt_q   <= '0;
            last_wr_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            mc_request_q <= mc_request_d;
            mc_addr_q    <= mc_addr_d;
            mc_write_q   <= mc_write_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            beat_cnt_q   <= beat_cnt_d;
            last_wr_q    <= last_wr_d;
        end
    end

    // Request acks and beat strobes pass straight through in the cycle they arrive.
    always_comb begin
        bus.rd_req_ack     = in_req & mem_ready & bus.mc_req_ack & owner_rd;
        bus.wr_req_ack     = in_req & mem_ready & bus.mc_req_ack & owner_wr;
        bus.rd_data_valid  = beat & owner_rd;
        bus.give_next_data = beat & owner_wr;
        bus.rd_data        = owner_rd ? bus.mc_rdata : 32'h0;
        bus.mc_wdata       = bus.wr_data;
    end

    // Registered status and controller-request outputs.
    always_comb begin
        bus.mc_request = mc_request_q;
        bus.mc_addr    = mc_addr_q;
        bus.mc_write   = mc_write_q;
        bus.owner      = owner_q;
        bus.busy       = busy_q;
    end

endmodule

// File: tb/tb_videomem_arbiter.sv
// tb_videomem_arbiter -- vector table for single read/write bursts plus
// hand-written sequences for contention, mem_ready loss and mid-request reset.
module tb_videomem_arbiter;

    localparam int ADDR_W    = 25;
    localparam int BURST_LEN = 4;

    logic mem_clock = 1'b0;
    logic reset_n   = 1'b0;
    logic mem_ready = 1'b0;

    videomem_arbiter_if #(.ADDR_W(ADDR_W)) vif();

    videomem_arbiter #(
        .BURST_LEN (BURST_LEN),
        .ADDR_W    (ADDR_W)
    ) dut (
        .mem_clock (mem_clock),
        .reset_n   (reset_n),
        .mem_ready (mem_ready),
        .bus       (vif.master)
    );

    always #5 mem_clock = ~mem_clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] rdq[$];
    logic [1:0]  grantq[$];

    // ctl : rd_request, wr_request, mc_req_ack, mc_give_next_data, mc_rdata_valid
    // exp : mc_request, mc_write, owner[1:0], busy, rd_req_ack, wr_req_ack, rd_data_valid, give_next_data
    typedef struct {
        logic [4:0]        ctl;
        logic [ADDR_W-1:0] rd_addr;
        logic [ADDR_W-1:0] wr_addr;
        logic [31:0]       wr_data;
        logic [31:0]       rdata;
        logic [8:0]        exp;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic [4:0] ctl, input logic [ADDR_W-1:0] ra,
                                 input logic [ADDR_W-1:0] wa, input logic [31:0] wd,
                                 input logic [31:0] rd, input logic [8:0] ex,
                                 input logic [ADDR_W-1:0] ea);
        vec_t v;
        v.ctl = ctl; v.rd_addr = ra; v.wr_addr = wa; v.wr_data = wd;
        v.rdata = rd; v.exp = ex; v.exp_addr = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic apply_ctl(input logic [4:0] c);
        vif.rd_request        = c[4];
        vif.wr_request        = c[3];
        vif.mc_req_ack        = c[2];
        vif.mc_give_next_data = c[1];
        vif.mc_rdata_valid    = c[0];
    endtask

    task automatic drive_idle();
        apply_ctl(5'b00000);
        vif.rd_addr  = '0;
        vif.wr_addr  = '0;
        vif.wr_data  = '0;
        vif.mc_rdata = '0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge mem_clock);
            #1;
            if (vif.mc_request === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic read_beat(input logic [31:0] d);
        @(negedge mem_clock);
        vif.mc_req_ack     = 1'b0;
        vif.mc_rdata_valid = 1'b1;
        vif.mc_rdata       = d;
        rdq.push_back(d);
        #1;
        check("read_beat_valid", 64'(vif.rd_data_valid), 64'd1);
        if (vif.rd_data_valid === 1'b1 && rdq.size() > 0)
            check("read_beat_data", 64'(vif.rd_data), 64'(rdq.pop_front()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] exp_own [4];
    bit ok;

    initial begin
        // read burst: reader asks, drops request in REQ, stray strobes in REQ/IDLE
        vecs.push_back(mkv(5'b10000, 25'h100, 25'h0, 32'h0, 32'h0,        9'b0_0_00_0_0000, 25'h0));
        vecs.push_back(mkv(5'b10001, 25'h100, 25'h0, 32'h0, 32'hDEAD_0001, 9'b1_0_01_1_0000, 25'h100));
        vecs.push_back(mkv(5'b00000, 25'h100, 25'h0, 32'h0, 32'h0,        9'b1_0_01_1_0000, 25'h100));
        vecs.push_back(mkv(5'b00100, 25'h100, 25'h0, 32'h0, 32'h0,        9'b1_0_01_1_1000, 25'h100));
        vecs.push_back(mkv(5'b00001, 25'h0,   25'h0, 32'h0, 32'hA0A0_0000, 9'b0_0_01_1_0010, 25'h0));
        vecs.push_back(mkv(5'b00000, 25'h0,   25'h0, 32'h0, 32'h0,        9'b0_0_01_1_0000, 25'h0));
        vecs.push_back(mkv(5'b00001, 25'h0,   25'h0, 32'h0, 32'hA0A0_0001, 9'b0_0_01_1_0010, 25'h0));
        vecs.push_back(mkv(5'b00001, 25'h0,   25'h0, 32'h0, 32'hA0A0_0002, 9'b0_0_01_1_0010, 25'h0));
        vecs.push_back(mkv(5'b00001, 25'h0,   25'h0, 32'h0, 32'hA0A0_0003, 9'b0_0_01_1_0010, 25'h0));
        vecs.push_back(mkv(5'b00001, 25'h0,   25'h0, 32'h0, 32'hBAD0_0000, 9'b0_0_00_0_0000, 25'h0));
        // write burst: stray read strobe mid-burst, stray give in IDLE afterwards
        vecs.push_back(mkv(5'b01000, 25'h0, 25'h2000, 32'hFFFF_FFFF, 32'h0, 9'b0_0_00_0_0000, 25'h0));
        vecs.push_back(mkv(5'b01000, 25'h0, 25'h2000, 32'hFFFF_FFFF, 32'h0, 9'b1_1_10_1_0000, 25'h2000));
        vecs.push_back(mkv(5'b01100, 25'h0, 25'h2000, 32'hFFFF_FFFF, 32'h0, 9'b1_1_10_1_0100, 25'h2000));
        vecs.push_back(mkv(5'b00010, 25'h0, 25'h0, 32'h1111_1111, 32'h0,    9'b0_1_10_1_0001, 25'h0));
        vecs.push_back(mkv(5'b00010, 25'h0, 25'h0, 32'h2222_2222, 32'h0,    9'b0_1_10_1_0001, 25'h0));
        vecs.push_back(mkv(5'b00001, 25'h0, 25'h0, 32'h2222_2222, 32'hCCCC, 9'b0_1_10_1_0000, 25'h0));
        vecs.push_back(mkv(5'b00010, 25'h0, 25'h0, 32'h3333_3333, 32'h0,    9'b0_1_10_1_0001, 25'h0));
        vecs.push_back(mkv(5'b00010, 25'h0, 25'h0, 32'h4444_4444, 32'h0,    9'b0_1_10_1_0001, 25'h0));
        vecs.push_back(mkv(5'b00010, 25'h0, 25'h0, 32'h5555_5555, 32'h0,    9'b0_1_00_0_0000, 25'h0));

`ifdef VIDEOMEM_ARB_RR_EN
        exp_own = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_own = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

        // reset values
        drive_idle();
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge mem_clock);
        #1;
        check("reset_outputs",
              64'({vif.mc_request, vif.rd_req_ack, vif.wr_req_ack, vif.give_next_data,
                   vif.rd_data_valid, vif.busy, vif.owner, vif.mc_write, vif.mc_addr}), 64'd0);

        // no arbitration while mem_ready is low
        reset_n = 1'b1;
        vif.rd_request = 1'b1;
        vif.rd_addr    = 25'h55;
        repeat (2) @(negedge mem_clock);
        #1;
        check("no_grant_before_ready", 64'({vif.mc_request, vif.busy, vif.owner}), 64'd0);
        @(negedge mem_clock);
        vif.rd_request = 1'b0;
        mem_ready      = 1'b1;

        // table-driven read and write bursts
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge mem_clock);
            apply_ctl(vecs[i].ctl);
            vif.rd_addr  = vecs[i].rd_addr;
            vif.wr_addr  = vecs[i].wr_addr;
            vif.wr_data  = vecs[i].wr_data;
            vif.mc_rdata = vecs[i].rdata;
            if (vecs[i].exp[1]) rdq.push_back(vecs[i].rdata);
            #1;
            check($sformatf("vec%0d_ctrl", i),
                  64'({vif.mc_request, vif.owner, vif.busy, vif.rd_req_ack, vif.wr_req_ack,
                       vif.rd_data_valid, vif.give_next_data}),
                  64'({vecs[i].exp[8], vecs[i].exp[6:0]}));
            if (vecs[i].exp[8])
                check($sformatf("vec%0d_addr_write", i), 64'({vif.mc_write, vif.mc_addr}),
                      64'({vecs[i].exp[7], vecs[i].exp_addr}));
            check($sformatf("vec%0d_mc_wdata", i), 64'(vif.mc_wdata), 64'(vecs[i].wr_data));
            if (vif.rd_data_valid === 1'b1 && rdq.size() > 0)
                check($sformatf("vec%0d_rd_data", i), 64'(vif.rd_data), 64'(rdq.pop_front()));
        end

        // contention: both clients request continuously for four bursts
        @(negedge mem_clock);
        drive_idle();
        reset_n = 1'b0;
        @(negedge mem_clock);
        reset_n = 1'b1;
        vif.rd_request = 1'b1;
        vif.rd_addr    = 25'h300;
        vif.wr_request = 1'b1;
        vif.wr_addr    = 25'h4000;
        for (int b = 0; b < 4; b++) begin
            wait_req(ok);
            check($sformatf("cont%0d_request_seen", b), 64'(ok), 64'd1);
            check($sformatf("cont%0d_owner", b), 64'(vif.owner), 64'(exp_own[b]));
            check($sformatf("cont%0d_addr_write", b), 64'({vif.mc_write, vif.mc_addr}),
                  (exp_own[b] == 2'b01) ? 64'({1'b0, 25'h300}) : 64'({1'b1, 25'h4000}));
            @(negedge mem_clock);
            vif.mc_req_ack = 1'b1;
            grantq.push_back(exp_own[b]);
            #1;
            if (grantq.size() > 0)
                check($sformatf("cont%0d_grant", b), 64'({vif.wr_req_ack, vif.rd_req_ack}),
                      64'(grantq.pop_front()));
            for (int k = 0; k < BURST_LEN; k++) begin
                @(negedge mem_clock);
                vif.mc_req_ack        = 1'b0;
                vif.mc_rdata_valid    = 1'b1;
                vif.mc_give_next_data = 1'b1;
                #1;
                check($sformatf("cont%0d_beat%0d", b, k),
                      64'({vif.give_next_data, vif.rd_data_valid}), 64'(exp_own[b]));
            end
            @(negedge mem_clock);
            vif.mc_rdata_valid    = 1'b0;
            vif.mc_give_next_data = 1'b0;
            if (b == 3) begin
                vif.rd_request = 1'b0;
                vif.wr_request = 1'b0;
            end
            #1;
            check($sformatf("cont%0d_done", b), 64'({vif.busy, vif.owner}), 64'd0);
        end

        // mem_ready lost after two beats, then a clean burst counts from zero
        @(negedge mem_clock);
        drive_idle();
        vif.rd_request = 1'b1;
        vif.rd_addr    = 25'h500;
        wait_req(ok);
        check("drop_request_seen", 64'(ok), 64'd1);
        @(negedge mem_clock);
        vif.rd_request = 1'b0;
        vif.mc_req_ack = 1'b1;
        #1;
        check("drop_rd_req_ack", 64'(vif.rd_req_ack), 64'd1);
        read_beat(32'hB000_0000);
        read_beat(32'hB000_0001);
        @(negedge mem_clock);
        vif.mc_rdata_valid = 1'b0;
        mem_ready = 1'b0;
        @(negedge mem_clock);
        #1;
        check("ready_drop_idle", 64'({vif.mc_request, vif.owner, vif.busy}), 64'd0);
        mem_ready      = 1'b1;
        vif.rd_request = 1'b1;
        vif.rd_addr    = 25'h600;
        wait_req(ok);
        check("redo_request_seen", 64'(ok), 64'd1);
        check("redo_addr", 64'(vif.mc_addr), 64'(25'h600));
        @(negedge mem_clock);
        vif.rd_request = 1'b0;
        vif.mc_req_ack = 1'b1;
        read_beat(32'hC000_0000);
        read_beat(32'hC000_0001);
        read_beat(32'hC000_0002);
        @(negedge mem_clock);
        vif.mc_rdata_valid = 1'b0;
        #1;
        check("redo_after_3_beats", 64'({vif.busy, vif.owner}), 64'({1'b1, 2'b01}));
        read_beat(32'hC000_0003);
        @(negedge mem_clock);
        vif.mc_rdata_valid = 1'b0;
        #1;
        check("redo_after_4_beats", 64'({vif.busy, vif.owner}), 64'd0);

        // asynchronous reset while a write request is pending
        vif.wr_request = 1'b1;
        vif.wr_addr    = 25'h7ABC;
        wait_req(ok);
        check("midreq_request_seen", 64'(ok), 64'd1);
        check("midreq_write", 64'({vif.mc_write, vif.owner}), 64'({1'b1, 2'b10}));
        vif.mc_req_ack = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("midreq_reset_outputs",
              64'({vif.mc_request, vif.rd_req_ack, vif.wr_req_ack, vif.give_next_data,
                   vif.rd_data_valid, vif.busy, vif.owner, vif.mc_write, vif.mc_addr}), 64'd0);
        drive_idle();
        @(negedge mem_clock);
        reset_n = 1'b1;
        repeat (2) @(negedge mem_clock);

        check("read_scoreboard_drained", 64'(rdq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
